// File: rtl/mix_columns_seq.sv
// Handshaked AES MixColumns / InvMixColumns engine. It mixes COLS_PER_CYCLE columns
// per clock, in place, in a 128-bit state register.
module mix_columns_seq #(
    parameter int BLOCK_LENGTH   = 128,
    parameter int COLS_PER_CYCLE = 1,
    parameter int SUPPORT_INV    = 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [BLOCK_LENGTH-1:0] IN,
    input  logic                    INV,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [BLOCK_LENGTH-1:0] OUT,
    output logic                    BUSY
);

    if (BLOCK_LENGTH != 128) begin : g_bad_length
        $error("mix_columns_seq: BLOCK_LENGTH must be 128");
    end
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int         NB   = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST = 2'(NB - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  r_state;
    logic [1:0]              r_cnt;
    logic                    r_inv;
    logic [BLOCK_LENGTH-1:0] r_data;

    logic                    w_accept;
    logic [1:0]              w_idx     [COLS_PER_CYCLE];
    logic [31:0]             w_col_in  [COLS_PER_CYCLE];
    logic [31:0]             w_col_out [COLS_PER_CYCLE];

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        if (inv && SUPPORT_INV != 0)
            return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                    m9[0] ^ me[1] ^ mb[2] ^ md[3],
                    md[0] ^ m9[1] ^ me[2] ^ mb[3],
                    mb[0] ^ md[1] ^ m9[2] ^ me[3]};
        return {x2[0] ^ x2[1] ^ a[1] ^ a[2] ^ a[3],
                a[0] ^ x2[1] ^ x2[2] ^ a[2] ^ a[3],
                a[0] ^ a[1] ^ x2[2] ^ x2[3] ^ a[3],
                x2[0] ^ a[0] ^ a[1] ^ a[2] ^ x2[3]};
    endfunction

    // Ready is gated by RST_N so it stays low for the whole reset window.
    assign IN_READY  = RST_N && ((r_state == S_IDLE) || (r_state == S_DONE && OUT_READY));
    assign w_accept  = IN_VALID && IN_READY;
    assign OUT_VALID = (r_state == S_DONE);
    assign BUSY      = (r_state != S_IDLE);
    assign OUT       = r_data;

    // Only COLS_PER_CYCLE mixers exist; the beat counter steers them across the state.
    always_comb begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            w_idx[j]     = 2'(int'(r_cnt) * COLS_PER_CYCLE + j);
            w_col_in[j]  = r_data[BLOCK_LENGTH-1-32*int'(w_idx[j]) -: 32];
            w_col_out[j] = mix_col(w_col_in[j], r_inv);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_inv   <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_data  <= IN;
                        r_inv   <= (SUPPORT_INV != 0) ? INV : 1'b0;
                        r_cnt   <= 2'd0;
                        r_state <= S_RUN;
                    end else if (r_state == S_DONE && OUT_READY) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    for (int j = 0; j < COLS_PER_CYCLE; j++)
                        r_data[BLOCK_LENGTH-1-32*int'(w_idx[j]) -: 32] <= w_col_out[j];
                    if (r_cnt == LAST)
                        r_state <= S_DONE;
                    else
                        r_cnt <= r_cnt + 2'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
